imem_load_controller: RTL and testbench
=======================================

Name: imem_load_controller

Overview:
- Sequences the instruction memory between two users: CPU instruction fetch (RUN) and a byte-serial program loader (LOAD).
- During a load it assembles 4 incoming bytes into one 32-bit word, writes it at a sequential word address and holds the CPU in stall.
- Sits between the fetch stage (PC), the instruction memory write/address port and the external loader link.

Parameters:
- DEPTH, 65, number of 32-bit words in instruction memory; highest legal word address is DEPTH-1.
- LEN_W, 7, width of load_len and of the internal word pointer.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_in  input  32  byte address from the fetch stage.
- load_start  input  1  request to begin a load; sampled in RUN only.
- load_len  input  LEN_W  number of words to load; sampled with load_start.
- byte_valid  input  1  loader byte strobe.
- byte_data  input  8  loader byte.
- byte_ready  output  1  controller accepts a byte this cycle.
- mem_addr  output  32  word address to instruction memory.
- mem_wd  output  32  write data to instruction memory.
- mem_we  output  1  instruction memory write enable.
- cpu_stall  output  1  freezes PC and the pipeline while high.
- load_done  output  1  one-cycle pulse at the end of a load.
- load_clip  output  1  sticky: the last load_len exceeded DEPTH.

Behaviour:
- Reset (asynchronous) clears all state and outputs:
  - state = RUN.
  - byte_ready, mem_we, cpu_stall, load_done and load_clip = 0.
  - mem_wd, the word pointer and the byte counter = 0.
- States: RUN, LOAD, WRITE, DONE.
- mem_addr, a combinational mux:
  - RUN: {2'b00, pc_in[31:2]}.
  - All other states: the word pointer, zero-extended.
- cpu_stall = 1 in LOAD, WRITE and DONE; 0 in RUN.
- RUN:
  - load_start=1 captures len = min(load_len, DEPTH), clears the word pointer and byte counter, goes to LOAD.
  - load_clip is set when load_len > DEPTH and cleared when load_len <= DEPTH, at that same capture.
  - load_start=1 with load_len=0 goes straight to DONE; no write occurs.
- LOAD:
  - byte_ready = 1.
  - A byte is accepted on byte_valid && byte_ready.
  - Assembly is big-endian: the first byte of each word lands in mem_wd[31:24], the fourth in [7:0]; the holding register shifts left 8 bits per accepted byte.
  - Accepting the 4th byte goes to WRITE.
  - byte_valid=0 holds state indefinitely.
- WRITE, exactly one cycle:
  - byte_ready = 0, mem_we = 1; mem_addr = pointer and mem_wd = assembled word are stable all cycle.
  - Next cycle the pointer increments and the byte counter clears.
  - If the incremented pointer equals len, go to DONE; otherwise go to LOAD.
- DONE, exactly one cycle: load_done = 1, cpu_stall still 1; then RUN.
  - In RUN the CPU fetches from pc_in on the first cycle after DONE.
- mem_we is 1 only in WRITE; it is never high in RUN.
- load_start is ignored outside RUN; a load cannot be restarted mid-sequence.
- Bytes presented outside LOAD are not accepted (byte_ready=0); the loader must hold them.
- Latency per word: 4 accepted-byte cycles + 1 WRITE cycle, so 5 cycles minimum.
- Full load of N words: from load_start to load_done = 5N+1 cycles minimum.
- The pointer never exceeds DEPTH-1, so no wrap-around write is possible.
- Reset mid-load:
  - Immediate return to RUN with stall released.
  - Already-written words remain in memory; any partial word is discarded.
- Simultaneous reset and load_start: reset wins.

Test Plan:
- Reset, then pc_in=0x0000_0010 -> mem_addr=0x4, cpu_stall=0, mem_we=0, byte_ready=0, load_clip=0.
- load_start, load_len=2, bytes 0x20,0x08,0x00,0x05,0xAC,0x08,0x00,0x00 one per cycle:
  - mem_we on cycle 5 at addr 0 with wd=0x2008_0005.
  - Then addr 1 with wd=0xAC08_0000.
  - load_done pulses once, 11 cycles after load_start.
  - cpu_stall falls the next cycle.
- Same load with byte_valid toggled 1/0 -> identical writes and data, just later; no byte is lost or duplicated.
- load_len=100 with DEPTH=65:
  - load_clip=1.
  - Exactly 65 writes, last at addr 64.
  - load_done follows the 65th write.
  - A second load with load_len=3 clears load_clip.
- load_len=0 -> DONE the next cycle, load_done pulse, no mem_we, stall high for 1 cycle only.
- Reset asserted after 6 accepted bytes of a 2-word load:
  - Word 0 written; the 2 bytes of word 1 are dropped.
  - state RUN and cpu_stall=0 immediately.
  - A new load restarts at addr 0.

Source files
------------

// File: rtl/imem_load_controller.sv
// Arbitrates the instruction memory port between CPU fetch (RUN) and a byte-serial
// program loader that packs 4 big-endian bytes per word and writes words sequentially.
module imem_load_controller #(
  parameter int DEPTH = 65,
  parameter int LEN_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  output logic             mem_we,
  output logic             cpu_stall,
  output logic             load_done,
  output logic             load_clip,
  output logic [1:0]       dbg_state
);

  // Loader handshake: a byte transfers on any rising edge where byte_valid && byte_ready;
  // byte_ready depends only on state, and the loader holds byte_data until it transfers.

  typedef enum logic [1:0] {RUN, LOAD, WRITE, DONE} state_t;

  localparam logic [LEN_W-1:0] DEPTH_W = LEN_W'(DEPTH);

  state_t           state, state_next;
  logic [LEN_W-1:0] ptr;
  logic [LEN_W-1:0] len;
  logic [1:0]       byte_cnt;
  logic [31:0]      wd_q;
  logic             clip_q;
  logic             last_word;
  logic             unused_pc_bits;

  assign last_word      = (ptr + LEN_W'(1)) == len;
  assign unused_pc_bits = ^pc_in[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      len      <= '0;
      byte_cnt <= '0;
      wd_q     <= '0;
      clip_q   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (load_start) begin
            len      <= (load_len > DEPTH_W) ? DEPTH_W : load_len;
            clip_q   <= load_len > DEPTH_W;
            ptr      <= '0;
            byte_cnt <= '0;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            wd_q     <= {wd_q[23:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          byte_cnt <= '0;
          // Pointer stays on the last written word so it never reaches DEPTH.
          if (!last_word) ptr <= ptr + LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    cpu_stall  = 1'b1;
    load_done  = 1'b0;
    case (state)
      RUN: begin
        cpu_stall = 1'b0;
        if (load_start) state_next = (load_len == '0) ? DONE : LOAD;
      end
      LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid && (byte_cnt == 2'd3)) state_next = WRITE;
      end
      WRITE: begin
        mem_we     = 1'b1;
        state_next = last_word ? DONE : LOAD;
      end
      DONE: begin
        load_done  = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign mem_addr  = (state == RUN) ? {2'b00, pc_in[31:2]} : {{(32-LEN_W){1'b0}}, ptr};
  assign mem_wd    = wd_q;
  assign load_clip = clip_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_imem_load_controller.sv
// Bench for imem_load_controller: random byte streams and load lengths checked against
// an expected write list derived from the load rules (word i = bytes 4i..4i+3, big-endian).
module tb_imem_load_controller;
  localparam int DEPTH = 65;
  localparam int LEN_W = 7;

  logic             clk;
  logic             reset;
  logic [31:0]      pc_in;
  logic             load_start;
  logic [LEN_W-1:0] load_len;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wd;
  logic             mem_we;
  logic             cpu_stall;
  logic             load_done;
  logic             load_clip;
  logic [1:0]       dbg_state;

  imem_load_controller #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .load_start(load_start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .cpu_stall(cpu_stall),
    .load_done(load_done), .load_clip(load_clip), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int done_cyc = 0;
  int stall_cycles = 0;
  int write_count = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stim[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clip_len(input int len);
    return (len > DEPTH) ? DEPTH : len;
  endfunction

  task automatic build_expect(input int len);
    for (int i = 0; i < clip_len(len); i++)
      exp_q.push_back({32'(i), stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]});
  endtask

  task automatic fill_random(input int nbytes);
    stim.delete();
    for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset) begin
      if (cpu_stall) stall_cycles++;
      if (load_done) begin
        done_count++;
        done_cyc = cyc;
      end
      check("we_outside_stall", {31'b0, mem_we & ~cpu_stall}, 32'd0);
      if (mem_we) begin
        write_count++;
        if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("we_addr", mem_addr, e[63:32]);
          check("we_data", mem_wd, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode 0: byte every cycle, 1: valid toggles 1/0, 2: random gaps
  task automatic feed_bytes(input int nbytes, input int mode, input bit poke);
    bit t;
    bit acc;
    int guard;
    t = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      guard = 0;
      do begin
        case (mode)
          0:       byte_valid = 1'b1;
          1:       begin byte_valid = t; t = ~t; end
          default: byte_valid = ($urandom_range(0, 99) >= 30);
        endcase
        byte_data = byte_valid ? stim[k] : 8'($urandom_range(0, 255));
        if (poke) begin
          load_start = 1'($urandom_range(0, 1));
          load_len   = LEN_W'($urandom_range(0, 127));
        end
        acc = byte_valid && byte_ready;
        @(negedge clk);
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        check("byte_timeout", 32'd1, 32'd0);
        break;
      end
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 20 && done_count == d0; i++) @(posedge clk);
    if (done_count == d0) check("done_timeout", 32'd1, 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic run_load(input int len, input int mode, input bit poke);
    int n, d0, s0, w0, start;
    n  = clip_len(len);
    build_expect(len);
    d0 = done_count;
    s0 = stall_cycles;
    w0 = write_count;
    pc_in = $urandom;
    @(negedge clk);
    load_start = 1'b1;
    load_len   = LEN_W'(len);
    start      = cyc;
    @(negedge clk);
    load_start = 1'b0;
    #1;
    check("clip_flag", {31'b0, load_clip}, {31'b0, (len > DEPTH)});
    check("stall_in_load", {31'b0, cpu_stall}, 32'd1);
    feed_bytes(4 * n, mode, poke);
    wait_done(d0);
    check("stall_released", {31'b0, cpu_stall}, 32'd0);
    check("run_addr", mem_addr, pc_in >> 2);
    check("write_count", write_count - w0, n);
    check("done_pulses", done_count - d0, 32'd1);
    check("exp_drained", exp_q.size(), 32'd0);
    if (mode == 0 && !poke) begin
      check("done_latency", done_cyc - start, 5 * n + 1);
      check("stall_cycles", stall_cycles - s0, 5 * n + 1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] fixed_bytes[8];
    int len;
    fixed_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    reset = 1'b1; pc_in = 32'h0; load_start = 1'b0; load_len = '0;
    byte_valid = 1'b0; byte_data = 8'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_stall", {31'b0, cpu_stall}, 32'd0);
    check("rst_done", {31'b0, load_done}, 32'd0);
    check("rst_clip", {31'b0, load_clip}, 32'd0);
    check("rst_wd", mem_wd, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pc_in = 32'h0000_0010;
    #1;
    check("run_addr_pc10", mem_addr, 32'h4);

    // directed two-word load, full rate then toggled valid
    for (int m = 0; m < 2; m++) begin
      stim.delete();
      foreach (fixed_bytes[i]) stim.push_back(fixed_bytes[i]);
      run_load(2, m, 1'b0);
    end

    // oversize length clips to DEPTH; next load clears the flag
    fill_random(4 * DEPTH);
    run_load(100, 0, 1'b0);
    fill_random(12);
    run_load(3, 0, 1'b0);
    run_load(0, 0, 1'b0);

    // reset after 6 accepted bytes of a 2-word load
    fill_random(8);
    exp_q.push_back({32'd0, stim[0], stim[1], stim[2], stim[3]});
    @(negedge clk);
    load_start = 1'b1;
    load_len   = LEN_W'(2);
    @(negedge clk);
    load_start = 1'b0;
    feed_bytes(6, 0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_stall", {31'b0, cpu_stall}, 32'd0);
    check("mid_rst_ready", {31'b0, byte_ready}, 32'd0);
    check("mid_rst_addr", mem_addr, pc_in >> 2);
    check("mid_rst_word0", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    fill_random(4);
    run_load(1, 0, 1'b0);

    // randomized loads with gaps and ignored mid-sequence load_start pulses
    for (int r = 0; r < 10; r++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(66, 127) : $urandom_range(0, 8);
      fill_random(4 * clip_len(len));
      run_load(len, 2, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
